// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4-Lite two-master arbiter.
// Holds the arbiter state encoding, response codes and default bus widths.
package axi_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        G_M0_R = 2'd1,
        G_M1_R = 2'd2,
        G_M1_W = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axi_arbiter_rr_pick2.sv
// Purpose: two-requester round-robin select, one-hot grant.
// Latency: purely combinational, no state.
// Backpressure: none; the caller holds 'last' and decides when a grant is consumed.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // 'last' = 1 means requester 1 won most recently, so requester 0 takes a tie.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/axi_arbiter.sv
// Purpose: share one AXI4-Lite slave port between the IFU (M0, read) and LSU (M1, read/write).
// Latency: grant one cycle after a request is seen in IDLE; granted paths are combinational.
// Backpressure: slave ready/response pass straight through; ungranted masters see ready=0.
module axi_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,

    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,

    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp
);

    arb_state_t state, state_nxt;
    logic       last_m1, last_nxt;
    logic       m1_wr_req;
    logic [1:0] req, gnt;

    assign m1_wr_req = m1_awvalid | m1_wvalid;
    assign req       = {m1_wr_req | m1_arvalid, m0_arvalid};

    rr_pick2 u_pick (
        .req  (req),
        .last (last_m1),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_m1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            last_m1 <= last_nxt;
        end
    end

    // A grant is held until the response handshake, never just the address phase.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_m1;
        case (state)
            IDLE: begin
                if (gnt[1]) begin
                    state_nxt = m1_wr_req ? G_M1_W : G_M1_R;
                end else if (gnt[0]) begin
                    state_nxt = G_M0_R;
                end
            end
            G_M0_R: begin
                if (s_rvalid && m0_rready) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            G_M1_R: begin
                if (s_rvalid && m1_rready) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            G_M1_W: begin
                if (s_bvalid && m1_bready) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Everything not routed by the current grant is held at zero, data included.
    always_comb begin
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = 2'b00;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_bready   = 1'b0;
        case (state)
            G_M0_R: begin
                s_arvalid  = m0_arvalid;
                s_araddr   = m0_araddr;
                m0_arready = s_arready;
                m0_rvalid  = s_rvalid;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                s_rready   = m0_rready;
            end
            G_M1_R: begin
                s_arvalid  = m1_arvalid;
                s_araddr   = m1_araddr;
                m1_arready = s_arready;
                m1_rvalid  = s_rvalid;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                s_rready   = m1_rready;
            end
            G_M1_W: begin
                s_awvalid  = m1_awvalid;
                s_awaddr   = m1_awaddr;
                m1_awready = s_awready;
                s_wvalid   = m1_wvalid;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                m1_wready  = s_wready;
                m1_bvalid  = s_bvalid;
                m1_bresp   = s_bresp;
                s_bready   = m1_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Bench for axi_arbiter: master and slave models around the DUT, directed steps then random batches.
module tb_axi_arbiter;
    import axi_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        wfirst;
    } wtx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;

    assign m0_rready = 1'b1;
    assign m1_rready = 1'b1;
    assign m1_bready = 1'b1;

    axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_0F0F);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        case (a[31:28])
            4'hE:    return DECERR;
            4'hF:    return SLVERR;
            4'hC:    return EXOKAY;
            default: return OKAY;
        endcase
    endfunction

    // ---------------- slave model ----------------
    int          slv_lat  = 2;
    bit          slv_rand = 1'b0;
    logic        r_busy, aw_got, w_got;
    int          r_cnt, b_cnt;
    logic [31:0] r_addr, slv_awaddr, slv_wdata;
    logic [3:0]  slv_wstrb;

    function automatic int pick_lat();
        return slv_rand ? int'($urandom_range(0, 3)) : slv_lat;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            s_arready <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
            s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0; s_bresp <= '0;
            r_busy <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; r_cnt <= 0; b_cnt <= 0;
        end else begin
            s_arready <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_awready <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wready  <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_arvalid && s_arready) begin
                r_busy <= 1'b1; r_addr <= s_araddr; r_cnt <= pick_lat();
            end else if (r_busy && !s_rvalid) begin
                if (r_cnt == 0) begin
                    s_rvalid <= 1'b1; s_rdata <= exp_rdata(r_addr); s_rresp <= exp_resp(r_addr);
                end else r_cnt <= r_cnt - 1;
            end
            if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0; r_busy <= 1'b0; s_rdata <= '0;
            end
            if (s_awvalid && s_awready) begin
                aw_got <= 1'b1; slv_awaddr <= s_awaddr; b_cnt <= pick_lat();
            end
            if (s_wvalid && s_wready) begin
                w_got <= 1'b1; slv_wdata <= s_wdata; slv_wstrb <= s_wstrb;
            end
            if (aw_got && w_got && !s_bvalid) begin
                if (b_cnt == 0) begin
                    s_bvalid <= 1'b1; s_bresp <= exp_resp(slv_awaddr);
                end else b_cnt <= b_cnt - 1;
            end
            if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end
        end
    end

    // ---------------- master models: relaunch in the release edge so requests stay pending ----------------
    logic [31:0] m0_q[$], m1r_q[$];
    wtx_t        m1w_q[$];
    int          m0_rd, m1r_rd, m1w_rd;
    logic        m0_busy, m1r_busy, m1w_busy, aw_pend;

    always @(posedge clk) begin
        if (rst) begin
            m0_arvalid <= 1'b0; m0_busy <= 1'b0; m0_araddr <= '0; m0_rd <= m0_q.size();
        end else begin
            if (m0_arvalid && m0_arready) m0_arvalid <= 1'b0;
            if ((m0_busy && m0_rvalid && m0_rready) || !m0_busy) begin
                if (m0_rd < m0_q.size()) begin
                    m0_araddr <= m0_q[m0_rd]; m0_rd <= m0_rd + 1;
                    m0_arvalid <= 1'b1; m0_busy <= 1'b1;
                end else m0_busy <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m1_arvalid <= 1'b0; m1r_busy <= 1'b0; m1_araddr <= '0; m1r_rd <= m1r_q.size();
        end else begin
            if (m1_arvalid && m1_arready) m1_arvalid <= 1'b0;
            if ((m1r_busy && m1_rvalid && m1_rready) || !m1r_busy) begin
                if (m1r_rd < m1r_q.size()) begin
                    m1_araddr <= m1r_q[m1r_rd]; m1r_rd <= m1r_rd + 1;
                    m1_arvalid <= 1'b1; m1r_busy <= 1'b1;
                end else m1r_busy <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m1_awvalid <= 1'b0; m1_wvalid <= 1'b0; m1w_busy <= 1'b0; aw_pend <= 1'b0;
            m1_awaddr <= '0; m1_wdata <= '0; m1_wstrb <= '0; m1w_rd <= m1w_q.size();
        end else begin
            if (m1_awvalid && m1_awready) m1_awvalid <= 1'b0;
            if (m1_wvalid && m1_wready) m1_wvalid <= 1'b0;
            if (aw_pend) begin m1_awvalid <= 1'b1; aw_pend <= 1'b0; end
            if ((m1w_busy && m1_bvalid && m1_bready) || !m1w_busy) begin
                if (m1w_rd < m1w_q.size()) begin
                    m1_awaddr <= m1w_q[m1w_rd].addr; m1_wdata <= m1w_q[m1w_rd].data;
                    m1_wstrb <= m1w_q[m1w_rd].strb; m1_wvalid <= 1'b1; m1w_busy <= 1'b1;
                    if (m1w_q[m1w_rd].wfirst) aw_pend <= 1'b1; else m1_awvalid <= 1'b1;
                    m1w_rd <= m1w_rd + 1;
                end else m1w_busy <= 1'b0;
            end
        end
    end

    function automatic bit bfm_idle();
        return !m0_busy && !m1r_busy && !m1w_busy && (m0_rd == m0_q.size()) &&
               (m1r_rd == m1r_q.size()) && (m1w_rd == m1w_q.size());
    endfunction

    // ---------------- checking ----------------
    int          n_chk = 0, n_pass = 0;
    int          order_q[$], exp_q[$];
    int          base;
    bit          model_last = 1'b0;
    logic        prev_idle = 1'b0, prev_req = 1'b0, prev_hs = 1'b0;
    logic [31:0] m0_last_rdata;
    logic [1:0]  m0_last_rresp, m1_last_bresp;
    logic [67:0] last_wr;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] all_outputs();
        return {m0_arready, m0_rvalid, m0_rdata, m0_rresp,
                m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_awready, m1_wready, m1_bvalid, m1_bresp,
                s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready};
    endfunction

    // One cycle: sample at the falling edge, check routing, latency and completions.
    task automatic step();
        logic idle, req, hs;
        @(negedge clk);
        idle = !s_rready && !s_bready;
        req  = m0_arvalid | m1_arvalid | m1_awvalid | m1_wvalid;
        hs   = (m0_rvalid && m0_rready) | (m1_rvalid && m1_rready) | (m1_bvalid && m1_bready);
        if (!rst) begin
            if (prev_idle && prev_req) chk("grant_latency", idle, 1'b0);
            if (prev_hs) chk("release_to_idle", idle, 1'b1);
            if (s_rvalid)
                chk("r_route", {m0_rvalid ^ m1_rvalid, m0_rvalid ? {m0_rdata, m0_rresp} : {m1_rdata, m1_rresp}},
                    {1'b1, s_rdata, s_rresp});
            if (s_bready) chk("wr_blocks_reads", {m0_arready, m0_rvalid, m1_arready, m1_rvalid}, 4'b0);
            if (m0_rvalid && m0_rready) begin
                chk("m0_rdata", {m0_rdata, m0_rresp}, {exp_rdata(m0_araddr), exp_resp(m0_araddr)});
                m0_last_rdata = m0_rdata; m0_last_rresp = m0_rresp; order_q.push_back(0);
            end
            if (m1_rvalid && m1_rready) begin
                chk("m1_rdata", {m1_rdata, m1_rresp}, {exp_rdata(m1_araddr), exp_resp(m1_araddr)});
                order_q.push_back(1);
            end
            if (m1_bvalid && m1_bready) begin
                chk("m1_write", {slv_awaddr, slv_wdata, slv_wstrb, m1_bresp},
                    {m1_awaddr, m1_wdata, m1_wstrb, exp_resp(m1_awaddr)});
                last_wr = {slv_awaddr, slv_wdata, slv_wstrb}; m1_last_bresp = m1_bresp;
                order_q.push_back(2);
            end
        end
        prev_idle = idle; prev_req = req; prev_hs = hs;
    endtask

    // Grant order from the arbitration rules, assuming every queued request stays pending.
    task automatic model(input int n0, input int n1r, input int n1w);
        bit pick1;
        exp_q.delete();
        while (n0 + n1r + n1w > 0) begin
            if (n0 > 0 && (n1r + n1w) > 0) pick1 = !model_last;
            else pick1 = (n0 == 0);
            if (pick1) begin
                if (n1w > 0) begin exp_q.push_back(2); n1w--; end
                else begin exp_q.push_back(1); n1r--; end
                model_last = 1'b1;
            end else begin
                exp_q.push_back(0); n0--; model_last = 1'b0;
            end
        end
    endtask

    task automatic run_batch(input string tag);
        int n = 0;
        while (!bfm_idle() && n < 2000) begin step(); n++; end
        chk({tag, "_done"}, bfm_idle(), 1'b1);
        step(); step();
        chk({tag, "_count"}, order_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < order_q.size(); i++)
            chk({tag, "_order"}, order_q[base + i], exp_q[i]);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [3:0] nib;
        case ($urandom_range(0, 3))
            0: nib = 4'h8; 1: nib = 4'hE; 2: nib = 4'hF; default: nib = 4'hC;
        endcase
        return {nib, 28'($urandom)};
    endfunction

    initial begin
        int n;
        wtx_t w;
        repeat (3) step();
        chk("reset_outputs_zero", all_outputs(), '0);
        rst = 1'b0;

        // simultaneous requests out of reset: M1 first, then M0
        base = order_q.size();
        m0_q.push_back(32'h8000_0004); m1r_q.push_back(32'h8000_1000);
        model(1, 1, 0); exp_q = '{1, 0};
        run_batch("t2_tie");

        // single IFU read, with grant latency observed directly
        base = order_q.size();
        m0_q.push_back(32'h8000_0000);
        model(1, 0, 0); exp_q = '{0};
        step();
        chk("t1_idle_cycle", {m0_arvalid, s_arvalid}, 2'b10);
        step();
        chk("t1_grant", {s_arvalid, s_araddr}, {1'b1, 32'h8000_0000});
        run_batch("t1_single");
        chk("t1_rdata", {m0_last_rdata, m0_last_rresp}, {32'h0000_0413, OKAY});

        // alternating fairness
        base = order_q.size();
        for (int i = 0; i < 3; i++) begin
            m0_q.push_back(32'h8000_0100 + 32'(i * 4));
            m1r_q.push_back(32'h8000_1100 + 32'(i * 4));
        end
        model(3, 3, 0); exp_q = '{1, 0, 1, 0, 1, 0};
        run_batch("t3_fair");

        // LSU write with W ahead of AW while M0 waits
        base = order_q.size();
        w = '{addr: 32'h8000_2000, data: 32'hDEAD_BEEF, strb: 4'b0011, wfirst: 1'b1};
        m1w_q.push_back(w); m0_q.push_back(32'h8000_0200);
        model(1, 0, 1); exp_q = '{2, 0};
        run_batch("t4_write");
        chk("t4_wr_values", last_wr, {32'h8000_2000, 32'hDEAD_BEEF, 4'b0011});
        chk("t4_bresp", m1_last_bresp, OKAY);

        // error pass-through, then arbitration carries on unchanged
        base = order_q.size();
        m0_q.push_back(32'hE000_0010);
        model(1, 0, 0); exp_q = '{0};
        run_batch("t5_err");
        chk("t5_rresp", m0_last_rresp, 2'b11);
        base = order_q.size();
        m0_q.push_back(32'h8000_0300); m1r_q.push_back(32'h8000_1300);
        model(1, 1, 0); exp_q = '{1, 0};
        run_batch("t5_after");

        // reset in the middle of an M1 read
        slv_lat = 40;
        m1r_q.push_back(32'h8000_3000);
        n = 0;
        step();
        while (!(m1r_busy && !m1_arvalid) && n < 50) begin step(); n++; end
        chk("t6_ar_accepted", {m1r_busy, m1_arvalid}, 2'b10);
        repeat (3) step();
        chk("t6_still_waiting", {s_rready, m1_rvalid}, 2'b10);
        rst = 1'b1;
        step();
        chk("t6_reset_zero", all_outputs(), '0);
        rst = 1'b0;
        model_last = 1'b0;
        slv_lat = 1;
        base = order_q.size();
        m0_q.push_back(32'h8000_0400);
        model(1, 0, 0); exp_q = '{0};
        step();
        chk("t6_idle_cycle", {m0_arvalid, s_arvalid}, 2'b10);
        step();
        chk("t6_regrant", {s_arvalid, s_araddr}, {1'b1, 32'h8000_0400});
        run_batch("t6_after");

        // random batches against the order model
        slv_rand = 1'b1;
        for (int b = 0; b < 10; b++) begin
            int n0, n1r, n1w;
            n0 = $urandom_range(0, 3); n1r = $urandom_range(0, 3); n1w = $urandom_range(0, 2);
            base = order_q.size();
            for (int i = 0; i < n0; i++) m0_q.push_back(rand_addr());
            for (int i = 0; i < n1r; i++) m1r_q.push_back(rand_addr());
            for (int i = 0; i < n1w; i++) begin
                w.addr = rand_addr(); w.data = $urandom; w.strb = 4'($urandom);
                w.wfirst = 1'($urandom_range(0, 1));
                m1w_q.push_back(w);
            end
            model(n0, n1r, n1w);
            run_batch("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
